// File: rtl/spi_frame_sequencer.sv
// SPI command decoder and pixel stream packer between the SPI slave
// byte interface and the pixel datapath.
module spi_frame_sequencer #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int PIX_BYTES = 6,
  parameter int NREG      = 8
) (
  input  logic                   clk_p,
  input  logic                   rst_p,
  input  logic                   css,
  input  logic                   byte_vld,
  input  logic [7:0]             byte_in,
  input  logic [7:0]             ret_data,
  output logic [7:0]             tx_byte,
  output logic [8*NREG-1:0]      reg_file,
  output logic                   frame_rst,
  output logic                   stream_on,
  output logic                   pix_vld,
  output logic [8*PIX_BYTES-1:0] pix_data,
  output logic [10:0]            pix_x,
  output logic [10:0]            pix_y,
  output logic                   frame_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CMD    = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  localparam int BCW = $clog2(PIX_BYTES + 4);

  localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
  localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);

  logic [1:0]       state;
  logic [BCW-1:0]   bc;
  logic [7:0]       b1;
  logic [7:0]       b2;
  logic [8*NREG-1:0] regs;

  logic bin_ok;
  logic b2_ok;
  logic pix_last;
  logic at_end;

  assign reg_file = regs;
  assign bin_ok   = int'(byte_in) < NREG;
  assign b2_ok    = int'(b2) < NREG;
  assign pix_last = bc == BCW'(PIX_BYTES - 1);
  assign at_end   = (pix_x == X_LAST) && (pix_y == Y_LAST);

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state      <= S_IDLE;
      bc         <= '0;
      b1         <= '0;
      b2         <= '0;
      regs       <= '0;
      tx_byte    <= 8'hFF;
      frame_rst  <= 1'b0;
      stream_on  <= 1'b0;
      pix_vld    <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_vld    <= 1'b0;
      frame_done <= 1'b0;

      // coordinates move on after the strobe that presented them
      if (frame_rst) begin
        pix_x <= '0;
        pix_y <= '0;
      end else if (pix_vld) begin
        if (pix_x == X_LAST) begin
          pix_x <= '0;
          if (pix_y == Y_LAST) pix_y <= '0;
          else                 pix_y <= pix_y + 11'd1;
        end else begin
          pix_x <= pix_x + 11'd1;
        end
      end

      if (!css) begin
        state     <= S_IDLE;
        bc        <= '0;
        stream_on <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_CMD;
            bc    <= '0;
          end
          S_CMD: begin
            if (byte_vld && bc != BCW'(3)) begin
              bc      <= bc + BCW'(1);
              tx_byte <= 8'hFF;
              if (bc == BCW'(0)) b1 <= byte_in;
              if (bc == BCW'(1)) begin
                b2 <= byte_in;
                if (b1 == 8'h81)
                  tx_byte <= bin_ok ? regs[int'(byte_in)*8 +: 8] : 8'h00;
              end
              if (bc == BCW'(2)) begin
                case (b1)
                  8'h80: if (b2_ok) regs[int'(b2)*8 +: 8] <= byte_in;
                  8'h55: begin
                    state     <= S_STREAM;
                    stream_on <= 1'b1;
                    bc        <= '0;
                  end
                  8'h40: frame_rst <= 1'b0;
                  8'h41: frame_rst <= 1'b1;
                  default: ;
                endcase
              end
            end
          end
          S_STREAM: begin
            if (byte_vld) begin
              tx_byte  <= ret_data;
              pix_data <= {pix_data[8*PIX_BYTES-9:0], byte_in};
              if (pix_last) begin
                bc         <= '0;
                pix_vld    <= 1'b1;
                frame_done <= at_end;
              end else begin
                bc <= bc + BCW'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer on a 4x2 frame with
// 6-byte pixels.
module tb_spi_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int PB = 6;
  localparam int NR = 8;

  typedef struct packed {
    logic [8*PB-1:0] d;
    logic [10:0]     x;
    logic [10:0]     y;
    logic            fd;
  } pix_t;

  logic            clk_p = 1'b0;
  logic            rst_p = 1'b1;
  logic            css = 1'b0;
  logic            byte_vld = 1'b0;
  logic [7:0]      byte_in = 8'h00;
  logic [7:0]      ret_data = 8'h00;
  logic [7:0]      tx_byte;
  logic [8*NR-1:0] reg_file;
  logic            frame_rst;
  logic            stream_on;
  logic            pix_vld;
  logic [8*PB-1:0] pix_data;
  logic [10:0]     pix_x;
  logic [10:0]     pix_y;
  logic            frame_done;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   pix_cnt = 0;
  int   mx = 0;
  int   my = 0;
  bit   frst = 1'b0;
  pix_t sb[$];

  spi_frame_sequencer #(
    .IMG_W(W), .IMG_H(H), .PIX_BYTES(PB), .NREG(NR)
  ) dut (
    .clk_p(clk_p), .rst_p(rst_p), .css(css),
    .byte_vld(byte_vld), .byte_in(byte_in), .ret_data(ret_data),
    .tx_byte(tx_byte), .reg_file(reg_file), .frame_rst(frame_rst),
    .stream_on(stream_on), .pix_vld(pix_vld), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done)
  );

  always #5 clk_p = ~clk_p;

  // one cycle; pixel strobes are popped and checked here
  task automatic tick();
    pix_t e;
    @(negedge clk_p);
    if (pix_vld) begin
      pix_cnt++;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexp_pix: got d=%h x=%0d y=%0d, none expected",
                 pix_data, pix_x, pix_y);
      end else begin
        e = sb.pop_front();
        if ({pix_data, pix_x, pix_y, frame_done} !== e) begin
          tests_failed++;
          $display("FAIL pix: got d=%h x=%0d y=%0d fd=%b exp d=%h x=%0d y=%0d fd=%b",
                   pix_data, pix_x, pix_y, frame_done, e.d, e.x, e.y, e.fd);
        end
      end
    end else if (frame_done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL fd_alone: got frame_done=1 without pix_vld, exp 0");
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in  = b;
    byte_vld = 1'b1;
    tick();
    byte_vld = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic open_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
    css = 1'b0;
    tick();
    css = 1'b1;
    tick();
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic send_pixel(input logic [8*PB-1:0] d);
    pix_t e;
    e.d  = d;
    e.x  = 11'(mx);
    e.y  = 11'(my);
    e.fd = (mx == W-1) && (my == H-1);
    sb.push_back(e);
    if (!frst) begin
      if (mx == W-1) begin
        mx = 0;
        my = (my == H-1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    for (int i = PB-1; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_tx"}, 64'(tx_byte), 64'hFF);
    chk({nm, "_regs"}, 64'(reg_file), 64'h0);
    chk({nm, "_flags"}, 64'({frame_rst, stream_on, pix_vld, frame_done}), 64'h0);
    chk({nm, "_pix"}, 64'({pix_data}), 64'h0);
    chk({nm, "_xy"}, 64'({pix_x, pix_y}), 64'h0);
  endtask

  task automatic test_reset();
    rst_p = 1'b1;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_p = 1'b0;
    tick();
  endtask

  task automatic test_reg_write();
    css = 1'b1;
    tick();
    send_byte(8'h80);
    chk("wr_tx1", 64'(tx_byte), 64'hFF);
    send_byte(8'h03);
    chk("wr_tx2", 64'(tx_byte), 64'hFF);
    send_byte(8'h5A);
    chk("wr_tx3", 64'(tx_byte), 64'hFF);
    chk("wr_reg3", 64'(reg_file), 64'h5A00_0000);
  endtask

  task automatic test_readback();
    css = 1'b0;
    tick();
    css = 1'b1;
    tick();
    send_byte(8'h81);
    chk("rd_tx1", 64'(tx_byte), 64'hFF);
    send_byte(8'h03);
    chk("rd_tx2", 64'(tx_byte), 64'h5A);
    send_byte(8'h00);
    chk("rd_tx3", 64'(tx_byte), 64'hFF);
    css = 1'b0;
    tick();
    css = 1'b1;
    tick();
    send_byte(8'h81);
    send_byte(8'h09);
    chk("rd_oor", 64'(tx_byte), 64'h00);
  endtask

  task automatic test_stream();
    pix_t e;
    int   n0;
    open_cmd(8'h55, 8'h00, 8'h00);
    chk("st_on", 64'(stream_on), 64'h1);
    e.d = 48'h112233445566; e.x = 0; e.y = 0; e.fd = 0;
    sb.push_back(e);
    mx = 1;
    n0 = pix_cnt;
    for (int i = 1; i <= PB; i++) begin
      ret_data = 8'($urandom);
      send_byte(8'(i * 8'h11));
      chk("st_tx", 64'(tx_byte), 64'(ret_data));
      if (i < PB) chk("st_nopix", 64'(pix_cnt - n0), 64'h0);
    end
    repeat (3) tick();
    chk("st_one_pix", 64'(pix_cnt - n0), 64'h1);
  endtask

  task automatic test_frame();
    rst_p = 1'b1;
    tick();
    rst_p = 1'b0;
    mx = 0;
    my = 0;
    open_cmd(8'h55, 8'h00, 8'h00);
    for (int p = 0; p < W*H + 1; p++)
      send_pixel({$urandom, 16'($urandom)});
    tick();
    chk("fr_drain", 64'(sb.size()), 64'h0);
  endtask

  task automatic test_back_to_back_abort();
    int n0;
    n0 = pix_cnt;
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    css      = 1'b0;
    byte_in  = 8'hA4;
    byte_vld = 1'b1;
    tick();
    byte_vld = 1'b0;
    chk("ab_stream_off", 64'(stream_on), 64'h0);
    repeat (3) tick();
    chk("ab_nopix", 64'(pix_cnt - n0), 64'h0);
    css = 1'b1;
    tick();
    send_byte(8'h55);
    send_byte(8'h00);
    send_byte(8'h00);
    send_pixel(48'hC0C1C2C3C4C5);
    tick();
    chk("ab_restart", 64'(pix_cnt - n0), 64'h1);
  endtask

  task automatic test_frame_rst();
    logic [8*NR-1:0] snap;
    open_cmd(8'h41, 8'h00, 8'h00);
    chk("frst_on", 64'(frame_rst), 64'h1);
    tick();
    chk("frst_xy0", 64'({pix_x, pix_y}), 64'h0);
    frst = 1'b1;
    mx = 0;
    my = 0;
    open_cmd(8'h55, 8'h00, 8'h00);
    send_pixel(48'h0102030405AA);
    send_pixel(48'h0102030405BB);
    tick();
    open_cmd(8'h40, 8'h00, 8'h00);
    chk("frst_off", 64'(frame_rst), 64'h0);
    frst = 1'b0;
    open_cmd(8'h80, 8'h05, 8'hC3);
    snap = reg_file;
    chk("frst_reg5", 64'(reg_file[47:40]), 64'hC3);
    open_cmd(8'hEE, 8'h00, 8'h00);
    chk("ee_noop", 64'({frame_rst, stream_on}), 64'h0);
    chk("ee_regs", 64'(reg_file), 64'(snap));
    open_cmd(8'h55, 8'h00, 8'h00);
    send_pixel(48'hDEADBEEF0001);
    tick();
    chk("frst_drain", 64'(sb.size()), 64'h0);
    send_byte(8'h77);
    send_byte(8'h78);
    rst_p = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst_p = 1'b0;
    css = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_readback();
    test_stream();
    test_frame();
    test_back_to_back_abort();
    test_frame_rst();
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
